// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, datapath width and PC constants.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCR              = 32'd4;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Architectural program-counter register with async reset and load enable.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VALUE = RESET_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VALUE;
        end else if (load) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC and instruction-fetch controller: fetches at PC over req/gnt/rvalid, hands
// the word to decode, and advances PC (sequential or redirect) on consume.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] current_addr_pc,
    input  logic [XLEN-1:0] next_addr_pc,
    input  logic            branch_taken,
    input  logic            halt,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            stall,
    output logic            misaligned,
    output logic [XLEN-1:0] retire_count
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic            consume;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        consume = 1'b0;
        unique case (state_q)
            BOOT:  state_d = REQ;
            REQ:   if (imem_gnt) state_d = WAIT;
            WAIT:  if (imem_rvalid) state_d = VALID;
            VALID: begin
                if (!stall) begin
                    consume = 1'b1;
                    state_d = halt ? HALT : REQ;
                end
            end
            HALT:  state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // Redirect targets are forced word-aligned; the low bits only raise a flag.
    assign pc_next = branch_taken ? {next_addr_pc[XLEN-1:2], 2'b00} : pc + PC_INCR;

    pc_reg #(
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (consume),
        .next_pc (pc_next),
        .pc      (pc)
    );

    assign current_addr_pc = pc;
    assign imem_addr       = pc;

    // Status outputs are flopped from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            misaligned   <= 1'b0;
            instr        <= '0;
            retire_count <= '0;
        end else begin
            imem_req    <= (state_d == REQ);
            instr_valid <= (state_d == VALID);
            misaligned  <= consume && branch_taken && (next_addr_pc[1:0] != 2'b00);
            if ((state_q == WAIT) && imem_rvalid) begin
                instr <= imem_rdata;
            end
            if (consume) begin
                retire_count <= retire_count + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with hand-computed expectations.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] current_addr_pc;
    logic [31:0] next_addr_pc;
    logic        branch_taken;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        misaligned;
    logic [31:0] retire_count;

    int unsigned n_vec;
    int unsigned n_err;
    logic [31:0] exp_pc;
    logic [31:0] exp_retire;

    pc_fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .current_addr_pc (current_addr_pc),
        .next_addr_pc    (next_addr_pc),
        .branch_taken    (branch_taken),
        .halt            (halt),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .misaligned      (misaligned),
        .retire_count    (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in REQ; fetch with immediate gnt/rvalid, then consume with given controls.
    task automatic fetch_consume(input logic [31:0] rdata, input logic br,
                                 input logic [31:0] target, input logic hlt);
        logic exp_mis;
        chk("fc_req", 32'(imem_req), 32'd1);
        chk("fc_addr", imem_addr, exp_pc);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = rdata;
        branch_taken = 1'b1; next_addr_pc = 32'hDEAD_BEEF; halt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("fc_wait_req", 32'(imem_req), 32'd0);
        step();
        imem_rvalid = 1'b0;
        chk("fc_valid", 32'(instr_valid), 32'd1);
        chk("fc_instr", instr, rdata);
        chk("fc_pc_hold", current_addr_pc, exp_pc);
        stall = 1'b0; branch_taken = br; next_addr_pc = target; halt = hlt;
        step();
        stall = 1'b1; branch_taken = 1'b0; next_addr_pc = 32'h0; halt = 1'b0;
        exp_pc     = br ? {target[31:2], 2'b00} : exp_pc + 32'd4;
        exp_retire = exp_retire + 32'd1;
        exp_mis    = br && (target[1:0] != 2'b00);
        chk("fc_pc", current_addr_pc, exp_pc);
        chk("fc_retire", retire_count, exp_retire);
        chk("fc_mis", 32'(misaligned), 32'(exp_mis));
        chk("fc_req_after", 32'(imem_req), hlt ? 32'd0 : 32'd1);
        chk("fc_valid_after", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; next_addr_pc = '0; branch_taken = 1'b0; halt = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; stall = 1'b1;
        exp_pc = 32'h0; exp_retire = 32'h0;

        step(); step();
        chk("rst_pc", current_addr_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_retire", retire_count, 32'h0);

        // Basic fetch: BOOT, REQ, WAIT, VALID
        rst_n = 1'b1;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1111_0000;
        step();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_valid0", 32'(instr_valid), 32'd0);
        step();
        chk("t1_wait_req", 32'(imem_req), 32'd0);
        step();
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_instr", instr, 32'h1111_0000);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        step();
        stall = 1'b1;
        chk("t1_pc", current_addr_pc, 32'h4);
        chk("t1_retire", retire_count, 32'd1);
        chk("t1_req_again", 32'(imem_req), 32'd1);
        exp_pc = 32'h4; exp_retire = 32'd1;

        // Delayed gnt and rvalid, stalled consume
        step();
        step();
        chk("t2_req_held", 32'(imem_req), 32'd1);
        imem_gnt = 1'b1; imem_rdata = 32'h2222_0004;
        step();
        imem_gnt = 1'b0;
        step();
        step();
        chk("t2_wait_valid", 32'(instr_valid), 32'd0);
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0; imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_pc", current_addr_pc, 32'h4);
            chk("t2_stall_instr", instr, 32'h2222_0004);
            chk("t2_stall_req", 32'(imem_req), 32'd0);
            chk("t2_stall_valid", 32'(instr_valid), 32'd1);
            step();
        end
        stall = 1'b0;
        step();
        stall = 1'b1;
        chk("t2_pc", current_addr_pc, 32'h8);
        chk("t2_retire", retire_count, 32'd2);
        step();
        chk("t2_one_consume", retire_count, 32'd2);
        exp_pc = 32'h8; exp_retire = 32'd2;

        // Sequential up to 0x10, then aligned and misaligned redirects
        fetch_consume(32'h3333_0008, 1'b0, 32'h0, 1'b0);
        fetch_consume(32'h4444_000C, 1'b0, 32'h0, 1'b0);
        chk("t3_pc10", current_addr_pc, 32'h10);
        fetch_consume(32'h5555_0010, 1'b1, 32'h40, 1'b0);
        chk("t3_pc40", current_addr_pc, 32'h40);
        fetch_consume(32'h6666_0040, 1'b1, 32'h43, 1'b0);
        chk("t3_pc40b", current_addr_pc, 32'h40);
        step();
        chk("t3_mis_pulse_end", 32'(misaligned), 32'd0);

        // Wrap of PC+4
        fetch_consume(32'h7777_0040, 1'b1, 32'hFFFF_FFFC, 1'b0);
        fetch_consume(32'h8888_FFFC, 1'b0, 32'h0, 1'b0);
        chk("t4_wrap_pc", current_addr_pc, 32'h0);
        chk("t4_wrap_mis", 32'(misaligned), 32'd0);

        // Halt, then stray memory activity
        fetch_consume(32'h9999_0000, 1'b0, 32'h0, 1'b1);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_halt_req", 32'(imem_req), 32'd0);
            chk("t5_halt_valid", 32'(instr_valid), 32'd0);
            chk("t5_halt_pc", current_addr_pc, 32'h4);
            chk("t5_halt_instr", instr, 32'h9999_0000);
        end
        chk("t5_halt_retire", retire_count, exp_retire);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; stall = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_pc", current_addr_pc, 32'h0);
        chk("t5_rst_retire", retire_count, 32'h0);

        // Reset during WAIT, late rvalid after release
        step();
        rst_n = 1'b1;
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("t6_in_wait", 32'(imem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_abort_req", 32'(imem_req), 32'd0);
        chk("t6_abort_instr", instr, 32'h0);
        step();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD2_BAD2;
        step();
        chk("t6_late_instr", instr, 32'h0);
        chk("t6_late_valid", 32'(instr_valid), 32'd0);
        chk("t6_req", 32'(imem_req), 32'd1);
        step();
        imem_rvalid = 1'b0;
        chk("t6_rvalid_in_req", instr, 32'h0);
        exp_pc = 32'h0; exp_retire = 32'h0;
        fetch_consume(32'hAAAA_0000, 1'b0, 32'h0, 1'b0);
        chk("t6_restart_pc", current_addr_pc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
